// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state encoding, PE mode constants and drain-length helper
package pe_pkg;

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, FIRE, CAPT, DRAIN} pe_state_t;

   localparam logic [1:0] MODE_WUPD = 2'b00;
   localparam logic [1:0] MODE_MVM  = 2'b01;

   // Weight-update results fill the whole Q bus; every other mode yields one word per neuron output.
   function automatic int drain_words(input logic [1:0] mode, input int neu_in, input int neu_out);
      return (mode == MODE_WUPD) ? (neu_in * neu_out / 2) : neu_out;
   endfunction

endpackage

// File: rtl/pe_loader_if.sv
// rtl/pe_loader_if.sv - input word stream and result stream between the host and pe_loader
interface pe_loader_if #(parameter int WORD_LEN = 16);

   logic                in_valid;
   logic                in_ready;
   logic [WORD_LEN-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [WORD_LEN-1:0] out_data;
   logic                out_last;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, out_last);

   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, out_last);

endinterface

// File: rtl/pe_out_serializer.sv
// rtl/pe_out_serializer.sv - selects the current result word from the capture buffer and flags the final one
module pe_out_serializer #(
   parameter int WORD_LEN = 16,
   parameter int WORDS    = 32,
   parameter int CW       = 7
) (
   input  logic                      active,
   input  logic [WORDS*WORD_LEN-1:0] words,
   input  logic [CW-1:0]             idx,
   input  logic [CW-1:0]             last_idx,
   output logic [WORD_LEN-1:0]       data,
   output logic                      last
);

   assign data = active ? words[idx*WORD_LEN +: WORD_LEN] : '0;
   assign last = active && (idx == last_idx);

endmodule

// File: rtl/pe_loader.sv
// rtl/pe_loader.sv - streams weights/neurons into a PE, fires it for PE_LAT+1 cycles and drains the result words
module pe_loader
   import pe_pkg::*;
#(
   parameter int WORD_LEN = 16,
   parameter int NEU_IN   = 16,
   parameter int NEU_OUT  = 4,
   parameter int PE_LAT   = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                load_w,
   input  logic [1:0]                          mode,
   input  logic                                abort,
   pe_loader_if.slave                          bus,
   output logic [WORD_LEN*NEU_IN-1:0]          pe_d,
   output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  pe_w,
   output logic                                pe_ce,
   output logic [1:0]                          pe_mode,
   input  logic [WORD_LEN*NEU_IN*NEU_OUT/2-1:0] pe_q,
   output logic                                busy,
   output logic                                done
);

   localparam int NW = NEU_IN * NEU_OUT;
   localparam int NQ = NW / 2;
   localparam int CW = $clog2(NW) + 1;

   localparam logic [CW-1:0] W_LAST = CW'(NW - 1);
   localparam logic [CW-1:0] D_LAST = CW'(NEU_IN - 1);
   localparam logic [CW-1:0] F_LAST = CW'(PE_LAT);

   pe_state_t             state;
   logic [CW-1:0]         cnt;
   logic [1:0]            mode_q;
   logic [WORD_LEN*NQ-1:0] obuf;
   logic [CW-1:0]         n_last;

   assign n_last       = CW'(drain_words(mode_q, NEU_IN, NEU_OUT) - 1);
   assign busy         = (state != IDLE);
   assign bus.in_ready = (state == LOAD_W) || (state == LOAD_D);
   assign bus.out_valid = (state == DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         mode_q  <= MODE_MVM;
         pe_d    <= '0;
         pe_w    <= '0;
         obuf    <= '0;
         pe_ce   <= 1'b0;
         pe_mode <= MODE_MVM;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         // Abort beats start and any handshake; partially written pe_w/pe_d stay as they are.
         if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            pe_ce <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     mode_q <= mode;
                     state  <= load_w ? LOAD_W : LOAD_D;
                     cnt    <= '0;
                  end
               end
               LOAD_W: begin
                  if (bus.in_valid) begin
                     pe_w[cnt*WORD_LEN +: WORD_LEN] <= bus.in_data;
                     if (cnt == W_LAST) begin
                        state <= LOAD_D;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               LOAD_D: begin
                  if (bus.in_valid) begin
                     pe_d[cnt*WORD_LEN +: WORD_LEN] <= bus.in_data;
                     if (cnt == D_LAST) begin
                        state   <= FIRE;
                        cnt     <= '0;
                        pe_ce   <= 1'b1;
                        pe_mode <= mode_q;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               FIRE: begin
                  if (cnt == F_LAST) begin
                     state <= CAPT;
                     cnt   <= '0;
                     pe_ce <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               CAPT: begin
                  obuf  <= pe_q;
                  state <= DRAIN;
                  cnt   <= '0;
               end
               DRAIN: begin
                  if (bus.out_ready) begin
                     if (cnt == n_last) begin
                        state <= IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   pe_out_serializer #(
      .WORD_LEN (WORD_LEN),
      .WORDS    (NQ),
      .CW       (CW)
   ) u_ser (
      .active   (state == DRAIN),
      .words    (obuf),
      .idx      (cnt),
      .last_idx (n_last),
      .data     (bus.out_data),
      .last     (bus.out_last)
   );

endmodule

// File: doc/pe_loader.md
PE_LOADER -- requirements
Module: pe_loader

Interface
REQ-001 Parameter WORD_LEN, default 16, SHALL set the bit width of every data word.
REQ-002 Parameter NEU_IN, default 16, SHALL set the number of neuron inputs per PE and SHALL be a power of 2.
REQ-003 Parameter NEU_OUT, default 4, SHALL set the number of neuron outputs per PE.
REQ-004 Parameter PE_LAT, default 2, SHALL set the PE cycles from ce-high to a valid Q.
REQ-005 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Clock and reset ports: clk, input, 1 bit, rising-edge clock; rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 Control ports: start (in, 1), pulse that begins a job; load_w (in, 1), reload the weights for this job; mode (in, 2), PE mode for this job; abort (in, 1), synchronous job cancel.
REQ-008 Input-stream ports: in_valid (in, 1); in_ready (out, 1); in_data (in, WORD_LEN), one weight or neuron word per handshake.
REQ-009 Output-stream ports: out_valid (out, 1); out_ready (in, 1); out_data (out, WORD_LEN), result word; out_last (out, 1), marks the final word.
REQ-010 PE-side ports: pe_d (out, WORD_LEN*NEU_IN); pe_w (out, WORD_LEN*NEU_IN*NEU_OUT); pe_ce (out, 1); pe_mode (out, 2); pe_q (in, WORD_LEN*NEU_IN*NEU_OUT/2).
REQ-011 Status ports: busy (out, 1), high whenever the state is not IDLE; done (out, 1), one-cycle pulse when a job completes.

Function
REQ-012 The state machine SHALL have the states IDLE, LOAD_W, LOAD_D, FIRE, CAPT and DRAIN.
REQ-013 In IDLE, start=1 SHALL latch mode and load_w, then go to LOAD_W if load_w=1, else to LOAD_D; start outside IDLE SHALL be ignored.
REQ-014 A word SHALL transfer only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD_W and LOAD_D.
REQ-015 LOAD_W SHALL write handshake k (k=0..NEU_IN*NEU_OUT-1) to pe_w[(k+1)*WORD_LEN-1 -: WORD_LEN], then go to LOAD_D after the last word.
REQ-016 LOAD_D SHALL write handshake k (k=0..NEU_IN-1) to pe_d word k, then go to FIRE.
REQ-017 pe_w and pe_d SHALL hold their values between jobs; with load_w=0 the previous weights SHALL be reused unchanged.
REQ-018 FIRE SHALL drive pe_ce=1 and pe_mode=latched mode for exactly PE_LAT+1 consecutive cycles, then go to CAPT.
REQ-019 In CAPT, pe_ce SHALL be 0, pe_q SHALL be registered into the output buffer, and the state SHALL go to DRAIN next cycle.
REQ-020 Outside FIRE, pe_ce SHALL be 0 and pe_mode SHALL keep its last driven value.
REQ-021 DRAIN word count N SHALL be NEU_IN*NEU_OUT/2 for mode 2'b00 and NEU_OUT for every other mode.
REQ-022 DRAIN SHALL present buffer word j (j=0..N-1, word 0 at the LSBs) with out_valid=1, advancing only on out_valid & out_ready.
REQ-023 While out_ready=0, out_data and out_last SHALL be held stable.
REQ-024 out_last SHALL be 1 only while word N-1 is presented.
REQ-025 On the handshake of word N-1, the state SHALL go to IDLE and done SHALL pulse for one cycle.
REQ-026 abort=1 in any state SHALL force IDLE next cycle, drop pe_ce, clear the counters and suppress done; a partially loaded pe_w/pe_d SHALL be kept as written, not rolled back.
REQ-027 abort SHALL take priority over start and over any handshake in the same cycle.
REQ-028 One word counter, sized $clog2(NEU_IN*NEU_OUT)+1, SHALL be shared by all states and cleared on every state entry.

Reset
REQ-029 rst_n=0 SHALL asynchronously set state=IDLE, counter=0, pe_d=0, pe_w=0, output buffer=0, pe_ce=0, pe_mode=2'b01, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
REQ-030 A reset asserted mid-job SHALL discard the job with no done pulse.

Structure
REQ-031 A shared package pe_pkg SHALL hold the state enumeration and the mode constants MODE_WUPD=2'b00 and MODE_MVM=2'b01.
REQ-032 The output-buffer word selection and out_last generation SHALL live in one sub-module, pe_out_serializer.

Verification
REQ-033 Defaults, load_w=1, mode=01, W all 16'h0001, D words 1..16 -> exactly 4 output words, out_last on the 4th, done one cycle after the 4th handshake, pe_ce high for 3 cycles.
REQ-034 Second job with load_w=0 and new D -> only 16 in_ready handshakes, pe_w bit-identical to the first job.
REQ-035 mode=00 -> 32 output words equal to the captured pe_q words 0..31 in order.
REQ-036 in_valid toggled randomly and out_ready held low for 5 cycles mid-drain -> no word lost or duplicated, out_data stable while stalled.
REQ-037 abort after 10 weight words, then a new job with start -> IDLE next cycle, no done pulse, and the new job completes correctly.
REQ-038 rst_n dropped during FIRE -> pe_ce=0 immediately (asynchronous), all outputs at their reset values.
